// File: rtl/axi4_slave_mem_bridge_pkg.sv
// Shared AXI4 constants, FSM state types and burst helper functions for the
// slave memory bridge and its burst trackers.
package axi4_slave_mem_bridge_pkg;

  localparam logic [1:0] AXI4_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI4_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI4_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  localparam int AXI4_MAX_BURST_LEN = 256;

  typedef enum logic [1:0] {
    ST_AXI_SLAVE_WRITE_IDLE,
    ST_AXI_SLAVE_WRITE_DATA,
    ST_AXI_SLAVE_WRITE_RESP
  } st_axi4_slave_write_t;

  typedef enum logic [1:0] {
    ST_AXI_SLAVE_READ_IDLE,
    ST_AXI_SLAVE_READ_FETCH,
    ST_AXI_SLAVE_READ_WAIT,
    ST_AXI_SLAVE_READ_VALID
  } st_axi4_slave_read_t;

  // Address of the next beat. Works on a 64-bit container; callers truncate
  // to their own address width, which gives the modulo-2^ADDR_W wrap.
  // Only INCR moves; FIXED and the error burst types hold the address.
  function automatic logic [63:0] axi4_next_addr(input logic [63:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
    logic [63:0] step;
    step = 64'd1 << size;
    if (burst == AXI4_BURST_INCR) begin
      return (addr & ~(step - 64'd1)) + step;
    end
    return addr;
  endfunction

  // WRAP is not supported by this slave, reserved is illegal, and a beat
  // wider than the data bus cannot be served.
  function automatic logic axi4_burst_err(input logic [1:0] burst,
                                          input logic [2:0] size,
                                          input logic [2:0] data_bytes_log2);
    return (burst == AXI4_BURST_WRAP) || (burst == AXI4_BURST_RSVD) ||
           (size > data_bytes_log2);
  endfunction

endpackage

// File: rtl/axi4_slave_mem_bridge_if.sv
// AXI4 (full) bus bundle between an interconnect master and the bridge.
interface axi4_slave_mem_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_slave_burst_tracker.sv
// Holds one accepted AW or AR request and walks it beat by beat: current
// address, beat index and whether the current beat is the last one.
module axi4_slave_burst_tracker
  import axi4_slave_mem_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ID_W-1:0]   req_id,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_burst,
  output logic              req_err,
  output logic [ID_W-1:0]   id,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              err
);

  localparam int         BEAT_W          = $clog2(AXI4_MAX_BURST_LEN);
  localparam logic [2:0] DATA_BYTES_LOG2 = 3'($clog2(DATA_W / 8));

  logic [ID_W-1:0]   id_q,    id_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        len_q,   len_d;
  logic [2:0]        size_q,  size_d;
  logic [1:0]        burst_q, burst_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic              err_q,   err_d;

  // Error classification of the request on the bus, before it is latched,
  // so the owning FSM can branch in the handshake cycle.
  assign req_err = axi4_burst_err(req_burst, req_size, DATA_BYTES_LOG2);

  // Next request context: a load restarts the walk, an advance steps one beat.
  always_comb begin
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    if (load) begin
      id_d    = req_id;
      addr_d  = req_addr;
      len_d   = req_len;
      size_d  = req_size;
      burst_d = req_burst;
      beat_d  = '0;
      err_d   = req_err;
    end else if (advance) begin
      addr_d = ADDR_W'(axi4_next_addr(64'(addr_q), size_q, burst_q));
      beat_d = beat_q + 1'b1;
    end
  end

  // Request context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign id   = id_q;
  assign addr = addr_q;
  assign last = (beat_q == len_q);
  assign err  = err_q;

endmodule

// File: rtl/axi4_slave_mem_bridge.sv
// AXI4 slave that splits bursts into single-beat accesses on a simple
// dual-port memory. Write and read sides are independent FSMs, each with
// its own burst tracker.
module axi4_slave_mem_bridge
  import axi4_slave_mem_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_slave_mem_bridge_if.slave s_axi,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W/8-1:0]  mem_wstrb,
  output logic                 mem_rreq,
  output logic [ADDR_W-1:0]    mem_raddr,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_rvalid
);

  // ---------------- write side ----------------
  st_axi4_slave_write_t wst_q, wst_d;
  logic                 w_mismatch_q, w_mismatch_d;
  logic                 aw_hs, w_hs;
  logic                 wtr_req_err, wtr_last, wtr_err;
  logic [ID_W-1:0]      wtr_id;
  logic [ADDR_W-1:0]    wtr_addr;

  axi4_slave_burst_tracker #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wtrack (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (aw_hs),
    .advance   (w_hs),
    .req_id    (s_axi.awid),
    .req_addr  (s_axi.awaddr),
    .req_len   (s_axi.awlen),
    .req_size  (s_axi.awsize),
    .req_burst (s_axi.awburst),
    .req_err   (wtr_req_err),
    .id        (wtr_id),
    .addr      (wtr_addr),
    .last      (wtr_last),
    .err       (wtr_err)
  );

  // Write FSM state and wlast-mismatch flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q        <= ST_AXI_SLAVE_WRITE_IDLE;
      w_mismatch_q <= 1'b0;
    end else begin
      wst_q        <= wst_d;
      w_mismatch_q <= w_mismatch_d;
    end
  end

  // Write next state: the beat counter, not wlast, decides when data ends.
  always_comb begin
    wst_d        = wst_q;
    w_mismatch_d = w_mismatch_q;
    case (wst_q)
      ST_AXI_SLAVE_WRITE_IDLE: begin
        if (aw_hs) begin
          wst_d        = ST_AXI_SLAVE_WRITE_DATA;
          w_mismatch_d = 1'b0;
        end
      end
      ST_AXI_SLAVE_WRITE_DATA: begin
        if (w_hs) begin
          if (s_axi.wlast != wtr_last) w_mismatch_d = 1'b1;
          if (wtr_last) wst_d = ST_AXI_SLAVE_WRITE_RESP;
        end
      end
      ST_AXI_SLAVE_WRITE_RESP: begin
        if (s_axi.bready) wst_d = ST_AXI_SLAVE_WRITE_IDLE;
      end
      default: wst_d = ST_AXI_SLAVE_WRITE_IDLE;
    endcase
  end

  // Write outputs: memory write is combinational with the W handshake.
  always_comb begin
    s_axi.awready = (wst_q == ST_AXI_SLAVE_WRITE_IDLE);
    s_axi.wready  = (wst_q == ST_AXI_SLAVE_WRITE_DATA);
    s_axi.bvalid  = (wst_q == ST_AXI_SLAVE_WRITE_RESP);
    s_axi.bid     = wtr_id;
    s_axi.bresp   = AXI4_RESP_OKAY;
    if ((wst_q == ST_AXI_SLAVE_WRITE_RESP) && (wtr_err || w_mismatch_q)) begin
      s_axi.bresp = AXI4_RESP_SLVERR;
    end
    aw_hs     = s_axi.awvalid && s_axi.awready;
    w_hs      = s_axi.wvalid && s_axi.wready;
    mem_we    = w_hs && !wtr_err;
    mem_waddr = wtr_addr;
    mem_wdata = s_axi.wdata;
    mem_wstrb = s_axi.wstrb;
  end

  // ---------------- read side ----------------
  st_axi4_slave_read_t  rst_q, rst_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 ar_hs, r_adv;
  logic                 rtr_req_err, rtr_last, rtr_err;
  logic [ID_W-1:0]      rtr_id;
  logic [ADDR_W-1:0]    rtr_addr;

  axi4_slave_burst_tracker #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rtrack (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ar_hs),
    .advance   (r_adv),
    .req_id    (s_axi.arid),
    .req_addr  (s_axi.araddr),
    .req_len   (s_axi.arlen),
    .req_size  (s_axi.arsize),
    .req_burst (s_axi.arburst),
    .req_err   (rtr_req_err),
    .id        (rtr_id),
    .addr      (rtr_addr),
    .last      (rtr_last),
    .err       (rtr_err)
  );

  // Read FSM state and captured response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q   <= ST_AXI_SLAVE_READ_IDLE;
      rdata_q <= '0;
      rresp_q <= AXI4_RESP_OKAY;
    end else begin
      rst_q   <= rst_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // Read next state: error bursts never touch memory and stream zero beats.
  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (rst_q)
      ST_AXI_SLAVE_READ_IDLE: begin
        if (ar_hs) begin
          if (rtr_req_err) begin
            rst_d   = ST_AXI_SLAVE_READ_VALID;
            rdata_d = '0;
            rresp_d = AXI4_RESP_SLVERR;
          end else begin
            rst_d = ST_AXI_SLAVE_READ_FETCH;
          end
        end
      end
      ST_AXI_SLAVE_READ_FETCH: rst_d = ST_AXI_SLAVE_READ_WAIT;
      ST_AXI_SLAVE_READ_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          rresp_d = AXI4_RESP_OKAY;
          rst_d   = ST_AXI_SLAVE_READ_VALID;
        end
      end
      ST_AXI_SLAVE_READ_VALID: begin
        if (s_axi.rready) begin
          if (rtr_last)     rst_d = ST_AXI_SLAVE_READ_IDLE;
          else if (!rtr_err) rst_d = ST_AXI_SLAVE_READ_FETCH;
        end
      end
      default: rst_d = ST_AXI_SLAVE_READ_IDLE;
    endcase
  end

  // Read outputs: rlast follows the tracker, which only moves on a handshake,
  // so it stays stable for as long as rvalid waits on rready.
  always_comb begin
    s_axi.arready = (rst_q == ST_AXI_SLAVE_READ_IDLE);
    s_axi.rvalid  = (rst_q == ST_AXI_SLAVE_READ_VALID);
    s_axi.rid     = rtr_id;
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
    s_axi.rlast   = s_axi.rvalid && rtr_last;
    ar_hs         = s_axi.arvalid && s_axi.arready;
    r_adv         = s_axi.rvalid && s_axi.rready && !rtr_last;
    mem_rreq      = (rst_q == ST_AXI_SLAVE_READ_FETCH);
    mem_raddr     = rtr_addr;
  end

endmodule

// File: tb/tb_axi4_slave_mem_bridge.sv
// Directed bench for axi4_slave_mem_bridge: a table of single-burst vectors
// plus hand sequences for backpressure and mid-burst reset.
module tb_axi4_slave_mem_bridge;
  import axi4_slave_mem_bridge_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_slave_mem_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  logic              mem_we, mem_rreq, mem_rvalid;
  logic [31:0]       mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [3:0]        mem_wstrb;

  axi4_slave_mem_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (axi.slave),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rreq   (mem_rreq),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  // Memory contents are a fixed pattern of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  // Read memory with MEM_LAT cycles of latency.
  logic [MEM_LAT-1:0] rv_pipe;
  logic [31:0]        ra_pipe [MEM_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_pipe <= '0;
    else begin
      rv_pipe    <= {rv_pipe[MEM_LAT-2:0], mem_rreq};
      ra_pipe[0] <= mem_raddr;
      for (int i = 1; i < MEM_LAT; i++) ra_pipe[i] <= ra_pipe[i-1];
    end
  end
  assign mem_rvalid = rv_pipe[MEM_LAT-1];
  assign mem_rdata  = mem_word(ra_pipe[MEM_LAT-1]);

  // Memory-side monitor.
  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  logic [3:0]  ws_q[$];
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
      ws_q.push_back(mem_wstrb);
    end
    if (mem_rreq) ra_q.push_back(mem_raddr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return axi.awready;
      1: return axi.wready;
      2: return axi.bvalid;
      3: return axi.arready;
      default: return axi.rvalid;
    endcase
  endfunction

  // Wait (sampling on falling edges) for a DUT signal, bounded.
  task automatic wait_hi(input int sel, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sig(sel)) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: got 0, expected 1", name);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit               wr;
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       strb;
    logic [31:0]      data0;
    int               bad_wlast;
    logic [1:0]       exp_resp;
    int               exp_mem;
    logic [3:0][31:0] exp_a;     // {beat3, beat2, beat1, beat0}
  } vec_t;

  task automatic run_write(input int n, input vec_t v);
    wa_q.delete(); wd_q.delete(); ws_q.delete();
    tick();
    axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
    axi.awsize = v.size; axi.awburst = v.burst; axi.awvalid = 1'b1;
    wait_hi(0, "awready");
    tick();
    axi.awvalid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      axi.wvalid = 1'b1;
      axi.wdata  = v.data0 + 32'(b);
      axi.wstrb  = v.strb;
      axi.wlast  = (b == int'(v.len)) || (b == v.bad_wlast);
      wait_hi(1, "wready");
      tick();
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
    wait_hi(2, "bvalid");
    chk($sformatf("v%0d bresp", n), 64'(axi.bresp), 64'(v.exp_resp));
    chk($sformatf("v%0d bid", n), 64'(axi.bid), 64'(v.id));
    tick();
    axi.bready = 1'b0;
    chk($sformatf("v%0d mem_we count", n), 64'(wa_q.size()), 64'(v.exp_mem));
    for (int k = 0; k < wa_q.size() && k < v.exp_mem; k++) begin
      chk($sformatf("v%0d waddr[%0d]", n, k), 64'(wa_q[k]), 64'(v.exp_a[k]));
      chk($sformatf("v%0d wdata[%0d]", n, k), 64'(wd_q[k]), 64'(v.data0 + 32'(k)));
      chk($sformatf("v%0d wstrb[%0d]", n, k), 64'(ws_q[k]), 64'(v.strb));
    end
    $display("txn %0d: WRITE id=%h addr=%h len=%0d size=%0d burst=%0d bresp=%0d writes=%0d",
             n, v.id, v.addr, v.len, v.size, v.burst, v.exp_resp, wa_q.size());
  endtask

  task automatic run_read(input int n, input vec_t v);
    logic [31:0] exp_d;
    ra_q.delete();
    tick();
    axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len;
    axi.arsize = v.size; axi.arburst = v.burst; axi.arvalid = 1'b1;
    wait_hi(3, "arready");
    tick();
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    for (int b = 0; b <= int'(v.len); b++) begin
      wait_hi(4, "rvalid");
      exp_d = (v.exp_resp == AXI4_RESP_OKAY) ? mem_word(v.exp_a[b]) : 32'h0;
      chk($sformatf("v%0d rdata[%0d]", n, b), 64'(axi.rdata), 64'(exp_d));
      chk($sformatf("v%0d rresp[%0d]", n, b), 64'(axi.rresp), 64'(v.exp_resp));
      chk($sformatf("v%0d rlast[%0d]", n, b), 64'(axi.rlast), 64'(b == int'(v.len)));
      chk($sformatf("v%0d rid[%0d]", n, b), 64'(axi.rid), 64'(v.id));
      tick();
    end
    axi.rready = 1'b0;
    chk($sformatf("v%0d mem_rreq count", n), 64'(ra_q.size()), 64'(v.exp_mem));
    for (int k = 0; k < ra_q.size() && k < v.exp_mem; k++)
      chk($sformatf("v%0d raddr[%0d]", n, k), 64'(ra_q[k]), 64'(v.exp_a[k]));
    $display("txn %0d: READ  id=%h addr=%h len=%0d size=%0d burst=%0d rresp=%0d reqs=%0d",
             n, v.id, v.addr, v.len, v.size, v.burst, v.exp_resp, ra_q.size());
  endtask

  task automatic run_vec(input int n, input vec_t v);
    if (v.wr) run_write(n, v);
    else      run_read(n, v);
  endtask

  vec_t vecs [12];

  initial begin
    logic [31:0] hold_d;
    int          hold_n;

    vecs[0]  = '{1'b1, 4'h5, 32'h100, 8'd3, 3'd2, AXI4_BURST_INCR, 4'hF, 32'hA0, -1,
                 AXI4_RESP_OKAY, 4, {32'h10C, 32'h108, 32'h104, 32'h100}};
    vecs[1]  = '{1'b0, 4'h9, 32'h40, 8'd2, 3'd2, AXI4_BURST_FIXED, 4'h0, 32'h0, -1,
                 AXI4_RESP_OKAY, 3, {32'h0, 32'h40, 32'h40, 32'h40}};
    vecs[2]  = '{1'b1, 4'h3, 32'h200, 8'd1, 3'd2, AXI4_BURST_WRAP, 4'hF, 32'hB0, -1,
                 AXI4_RESP_SLVERR, 0, {4{32'h0}}};
    vecs[3]  = '{1'b0, 4'hA, 32'h300, 8'd1, 3'd2, AXI4_BURST_WRAP, 4'h0, 32'h0, -1,
                 AXI4_RESP_SLVERR, 0, {4{32'h0}}};
    vecs[4]  = '{1'b1, 4'h1, 32'h20, 8'd3, 3'd2, AXI4_BURST_INCR, 4'hF, 32'h10, 1,
                 AXI4_RESP_SLVERR, 4, {32'h2C, 32'h28, 32'h24, 32'h20}};
    vecs[5]  = '{1'b1, 4'h2, 32'h0, 8'd0, 3'd3, AXI4_BURST_INCR, 4'hF, 32'h55, -1,
                 AXI4_RESP_SLVERR, 0, {4{32'h0}}};
    vecs[6]  = '{1'b0, 4'hC, 32'h8, 8'd0, 3'd3, AXI4_BURST_INCR, 4'h0, 32'h0, -1,
                 AXI4_RESP_SLVERR, 0, {4{32'h0}}};
    vecs[7]  = '{1'b0, 4'h7, 32'h103, 8'd2, 3'd1, AXI4_BURST_INCR, 4'h0, 32'h0, -1,
                 AXI4_RESP_OKAY, 3, {32'h0, 32'h106, 32'h104, 32'h103}};
    vecs[8]  = '{1'b1, 4'hE, 32'hFFFF_FFF8, 8'd2, 3'd2, AXI4_BURST_INCR, 4'hF, 32'hE0, -1,
                 AXI4_RESP_OKAY, 3, {32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}};
    vecs[9]  = '{1'b0, 4'hF, 32'h10, 8'd0, 3'd2, AXI4_BURST_RSVD, 4'h0, 32'h0, -1,
                 AXI4_RESP_SLVERR, 0, {4{32'h0}}};
    vecs[10] = '{1'b1, 4'h6, 32'h51, 8'd2, 3'd0, AXI4_BURST_INCR, 4'h2, 32'h60, -1,
                 AXI4_RESP_OKAY, 3, {32'h0, 32'h53, 32'h52, 32'h51}};
    vecs[11] = '{1'b0, 4'h4, 32'h1000, 8'd3, 3'd2, AXI4_BURST_INCR, 4'h0, 32'h0, -1,
                 AXI4_RESP_OKAY, 4, {32'h100C, 32'h1008, 32'h1004, 32'h1000}};

    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // Reset values, sampled while reset is held.
    repeat (3) @(negedge clk);
    chk("reset awready", 64'(axi.awready), 64'd1);
    chk("reset arready", 64'(axi.arready), 64'd1);
    chk("reset wready",  64'(axi.wready),  64'd0);
    chk("reset bvalid",  64'(axi.bvalid),  64'd0);
    chk("reset rvalid",  64'(axi.rvalid),  64'd0);
    chk("reset rlast",   64'(axi.rlast),   64'd0);
    chk("reset mem_we",  64'(mem_we),      64'd0);
    chk("reset mem_rreq", 64'(mem_rreq),   64'd0);
    chk("reset bresp",   64'(axi.bresp),   64'd0);
    chk("reset rresp",   64'(axi.rresp),   64'd0);
    chk("reset bid",     64'(axi.bid),     64'd0);
    chk("reset rid",     64'(axi.rid),     64'd0);
    chk("reset rdata",   64'(axi.rdata),   64'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Read backpressure: rready low for 5 cycles on beat 2 of 3.
    ra_q.delete();
    tick();
    axi.arid = 4'h3; axi.araddr = 32'h80; axi.arlen = 8'd2; axi.arsize = 3'd2;
    axi.arburst = AXI4_BURST_INCR; axi.arvalid = 1'b1;
    wait_hi(3, "bp arready");
    tick();
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    wait_hi(4, "bp rvalid0");
    chk("bp rdata0", 64'(axi.rdata), 64'(32'hC000_0080));
    tick();
    axi.rready = 1'b0;
    wait_hi(4, "bp rvalid1");
    hold_d = axi.rdata;
    hold_n = ra_q.size();
    chk("bp rdata1", 64'(hold_d), 64'(32'hC000_0084));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold rvalid c%0d", c), 64'(axi.rvalid), 64'd1);
      chk($sformatf("bp hold rdata c%0d", c), 64'(axi.rdata), 64'(hold_d));
      chk($sformatf("bp hold rlast c%0d", c), 64'(axi.rlast), 64'd0);
      chk($sformatf("bp hold rresp c%0d", c), 64'(axi.rresp), 64'(AXI4_RESP_OKAY));
      chk($sformatf("bp hold rreq c%0d", c), 64'(ra_q.size()), 64'(hold_n));
    end
    tick();
    axi.rready = 1'b1;
    tick();
    wait_hi(4, "bp rvalid2");
    chk("bp rdata2", 64'(axi.rdata), 64'(32'hC000_0088));
    chk("bp rlast2", 64'(axi.rlast), 64'd1);
    tick();
    axi.rready = 1'b0;
    chk("bp rreq total", 64'(ra_q.size()), 64'd3);
    $display("txn 12: READ  id=3 addr=80 len=2 with rready stalled 5 cycles");

    // Write response backpressure: bready low for 5 cycles.
    tick();
    axi.awid = 4'h8; axi.awaddr = 32'h400; axi.awlen = 8'd0; axi.awsize = 3'd2;
    axi.awburst = AXI4_BURST_INCR; axi.awvalid = 1'b1;
    wait_hi(0, "bb awready");
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b1; axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wlast = 1'b1;
    wait_hi(1, "bb wready");
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    wait_hi(2, "bb bvalid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bb hold bvalid c%0d", c), 64'(axi.bvalid), 64'd1);
      chk($sformatf("bb hold bid c%0d", c), 64'(axi.bid), 64'h8);
      chk($sformatf("bb hold awready c%0d", c), 64'(axi.awready), 64'd0);
    end
    tick();
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    @(negedge clk);
    chk("bb bvalid after", 64'(axi.bvalid), 64'd0);
    chk("bb awready after", 64'(axi.awready), 64'd1);
    $display("txn 13: WRITE id=8 addr=400 len=0 with bready stalled 5 cycles");

    // Reset in the middle of a len=7 write and a len=7 read.
    tick();
    axi.awid = 4'hB; axi.awaddr = 32'h500; axi.awlen = 8'd7; axi.awsize = 3'd2;
    axi.awburst = AXI4_BURST_INCR; axi.awvalid = 1'b1;
    wait_hi(0, "rs awready");
    tick();
    axi.awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi.wvalid = 1'b1; axi.wdata = 32'h900 + 32'(b); axi.wstrb = 4'hF; axi.wlast = 1'b0;
      wait_hi(1, "rs wready");
      tick();
    end
    axi.wvalid = 1'b0;
    axi.arid = 4'hD; axi.araddr = 32'h600; axi.arlen = 8'd7; axi.arsize = 3'd2;
    axi.arburst = AXI4_BURST_INCR; axi.arvalid = 1'b1;
    wait_hi(3, "rs arready");
    tick();
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    wait_hi(4, "rs rvalid0");
    tick();
    wait_hi(4, "rs rvalid1");
    rst_n = 1'b0;
    tick();
    axi.rready = 1'b0;
    @(negedge clk);
    chk("rs rvalid", 64'(axi.rvalid), 64'd0);
    chk("rs bvalid", 64'(axi.bvalid), 64'd0);
    chk("rs wready", 64'(axi.wready), 64'd0);
    chk("rs awready", 64'(axi.awready), 64'd1);
    chk("rs arready", 64'(axi.arready), 64'd1);
    chk("rs rlast", 64'(axi.rlast), 64'd0);
    tick();
    rst_n = 1'b1;
    $display("txn 14: reset during beat 2 of len=7 write and len=7 read");

    run_vec(15, vecs[0]);
    run_vec(16, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem_bridge.md
Name: axi4_slave_mem_bridge

Overview:
- AXI4 (full) slave that terminates burst transactions from an interconnect master.
- Converts each burst into per-beat accesses on a simple dual-port memory interface: one write port, one read port.
- It is the responder counterpart to the team's AXI4 master, and sits in front of BRAM or register banks that need burst access.
- Read and write channels run as independent state machines.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data bus width; must be 32, 64 or 128.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_aw{id,addr,len,size,burst}  in  ID_W/ADDR_W/8/3/2  write address
- s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata  in  DATA_W; s_axi_wstrb in DATA_W/8; s_axi_wlast in 1; s_axi_wvalid in 1; s_axi_wready out 1
- s_axi_bid out ID_W; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_ar{id,addr,len,size,burst}  in  same widths as AW; s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rid out ID_W; s_axi_rdata out DATA_W; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1
- mem_we  out  1  write strobe, one beat
- mem_waddr  out  ADDR_W  byte address of the beat
- mem_wdata  out  DATA_W
- mem_wstrb  out  DATA_W/8
- mem_rreq  out  1  read request pulse
- mem_raddr  out  ADDR_W
- mem_rdata  in  DATA_W
- mem_rvalid  in  1  read data valid; any latency of 1 cycle or more

Behaviour:
- Reset (async, rst_n=0):
  - Both FSMs go to IDLE and any in-flight burst is discarded.
  - awready=1, arready=1.
  - wready, bvalid, rvalid, rlast, mem_we and mem_rreq are 0.
  - bresp, rresp, bid, rid and rdata are 0.
- Burst error: the burst is an error burst if burst==WRAP (2'b10), or burst==reserved, or size > log2(DATA_W/8). Error bursts perform no memory access.
- Address generation:
  - FIXED: the same address for every beat.
  - INCR: next = (addr & ~(2^size-1)) + 2^size, computed in ADDR_W bits and wrapping modulo 2^ADDR_W.
  - The 4 KB boundary is not checked.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch id, addr, len, size and error flag; set beat count to 0; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready beat raises mem_we in the same cycle with the current address, wdata and wstrb; mem_we is suppressed on error bursts. The address then advances.
  - After beat index len, go to W_RESP. The beat counter is authoritative.
  - A wlast mismatch is wlast=1 before the final beat or wlast=0 on the final beat. On a mismatch the burst continues to its counted end, and the response becomes SLVERR.
  - W_RESP: bvalid=1, bid = latched id, bresp = OKAY, or SLVERR on error or mismatch. Hold until bready, then go to W_IDLE with awready=1 on the next cycle.
  - No new AW is accepted while in W_DATA or W_RESP.
- Read FSM states: R_IDLE, R_FETCH, R_WAIT, R_VALID.
  - R_IDLE: arready=1. On handshake, latch the fields and go to R_FETCH. Error bursts go directly to R_VALID with rdata=0 and rresp=SLVERR.
  - R_FETCH: one-cycle mem_rreq=1 with mem_raddr = current address, then R_WAIT.
  - R_WAIT: on mem_rvalid, register rdata, rresp=OKAY and rlast=(beat==len), then go to R_VALID.
  - R_VALID: rvalid=1 and rid = latched id; rdata, rresp and rlast are held stable until rready.
    - On rvalid&rready with a beat that is not last: advance the address and go to R_FETCH (or stay in R_VALID for error bursts, updating rlast).
    - On the last beat: go to R_IDLE.
  - Throughput is 1 beat per (3 + memory latency - 1) cycles for non-error bursts.
- Simultaneous events:
  - Read and write traffic are fully concurrent.
  - Reading and writing the same address in the same cycle is memory-defined; the bridge does not order the two.
- len=0: a single beat; rlast=1 and the write goes straight from W_DATA to W_RESP after one beat.

Decomposition:
- The following are added to axi_lib_pkg:
  - enums st_axi4_slave_write_t (ST_AXI_SLAVE_WRITE_IDLE/DATA/RESP) and st_axi4_slave_read_t (ST_AXI_SLAVE_READ_IDLE/FETCH/WAIT/VALID);
  - function axi4_next_addr(addr, size, burst);
  - function axi4_burst_err(burst, size, data_bytes_log2).
- Existing constants are reused: AXI4_BURST_*, AXI4_RESP_* and AXI4_MAX_BURST_LEN.
- Sub-module axi4_slave_burst_tracker: latches one AW/AR request and provides the address, beat count and last flag. It is instantiated twice.

Test Plan:
- Write INCR, awaddr=0x100, len=3, size=2, 4 beats 0xA0..0xA3, strb=0xF → mem_we at 0x100/0x104/0x108/0x10C with matching data; bresp=OKAY; bid echoes 0x5.
- Read FIXED, araddr=0x40, len=2, memory latency 2 → 3 mem_rreq all at 0x40; rlast only on beat 3; rresp=OKAY; rid echoed.
- WRAP write len=1 → no mem_we; bresp=SLVERR. WRAP read len=1 → 2 beats rdata=0, rresp=SLVERR, rlast on beat 2.
- Write len=3 with wlast asserted on beat 2 → all 4 beats written, bresp=SLVERR; size=3 on DATA_W=32 → SLVERR.
- rready held low for 5 cycles mid-burst → rdata, rresp and rlast stable; no extra mem_rreq; bready low → bvalid held.
- Assert rst_n=0 during beat 2 of a len=7 read and a len=7 write → next cycle rvalid=bvalid=wready=0, awready=arready=1; a fresh burst afterwards completes correctly.
